// File: rtl/nvdla_sdp_mcif_rd_responder_pkg.sv
// Shared payload layout, beat geometry and FSM encoding for the SDP MCIF read responder.
package nvdla_sdp_mcif_rd_responder_pkg;

    localparam int REQ_PD_W     = 47;
    localparam int REQ_ADDR_LSB = 0;
    localparam int REQ_ADDR_W   = 32;
    localparam int REQ_SIZE_LSB = 32;
    localparam int REQ_SIZE_W   = 15;

    localparam int RSP_PD_W     = 65;
    localparam int RSP_DATA_LSB = 0;
    localparam int RSP_DATA_W   = 64;
    localparam int RSP_MASK_BIT = 64;

    localparam int BEAT_BYTES   = 8;
    localparam int BEAT_SHIFT   = $clog2(BEAT_BYTES);
    localparam int WORD_ADDR_W  = REQ_ADDR_W - BEAT_SHIFT;

    typedef struct packed {
        logic [REQ_SIZE_W-1:0] size;
        logic [REQ_ADDR_W-1:0] addr;
    } req_pd_t;

    typedef struct packed {
        logic                  mask;
        logic [RSP_DATA_W-1:0] data;
    } rsp_pd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    function automatic logic [WORD_ADDR_W-1:0] word_addr_of(input logic [REQ_ADDR_W-1:0] byte_addr);
        return byte_addr[REQ_ADDR_W-1:BEAT_SHIFT];
    endfunction

endpackage

// File: rtl/nvdla_sdp_mcif_rd_responder_if.sv
// SDP <-> MCIF read channel: request, response and latency-FIFO credit return.
interface nvdla_sdp_mcif_rd_responder_if;
    import nvdla_sdp_mcif_rd_responder_pkg::*;

    logic                sdp2mcif_rd_req_valid;
    logic                sdp2mcif_rd_req_ready;
    logic [REQ_PD_W-1:0] sdp2mcif_rd_req_pd;
    logic                mcif2sdp_rd_rsp_valid;
    logic                mcif2sdp_rd_rsp_ready;
    logic [RSP_PD_W-1:0] mcif2sdp_rd_rsp_pd;
    logic                sdp2mcif_rd_cdt_lat_fifo_pop;

    modport master (
        output sdp2mcif_rd_req_valid, sdp2mcif_rd_req_pd, mcif2sdp_rd_rsp_ready,
               sdp2mcif_rd_cdt_lat_fifo_pop,
        input  sdp2mcif_rd_req_ready, mcif2sdp_rd_rsp_valid, mcif2sdp_rd_rsp_pd
    );

    modport slave (
        input  sdp2mcif_rd_req_valid, sdp2mcif_rd_req_pd, mcif2sdp_rd_rsp_ready,
               sdp2mcif_rd_cdt_lat_fifo_pop,
        output sdp2mcif_rd_req_ready, mcif2sdp_rd_rsp_valid, mcif2sdp_rd_rsp_pd
    );

endinterface

// File: rtl/nvdla_sdp_mcif_rd_responder_skid2.sv
// Two-entry response buffer between the memory return path and the response port.
// Latency: push visible at the head the cycle after; backpressure: pop only when valid, push ignored when full.
// Upstream issue logic guarantees a push never arrives while both entries are held.
module nvdla_sdp_rsp_skid2 #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data_out,
    output logic [1:0]   count
);

    logic [W-1:0] entry [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (cnt != 2'd2);
    assign do_pop  = pop && (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entry[wr_ptr] <= data_in;
    end

    assign valid    = (cnt != 2'd0);
    assign data_out = entry[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/nvdla_sdp_mcif_rd_responder.sv
// Serves SDP read bursts from a 1-cycle backing memory, one 8-byte beat per cycle, credit-limited.
// Latency: accept at T, memory read at T+1, response valid from edge T+2.
// Backpressure: issue stalls on zero credits or when the 2-entry output buffer would overfill.
module nvdla_sdp_mcif_rd_responder
    import nvdla_sdp_mcif_rd_responder_pkg::*;
#(
    parameter int LAT_FIFO_DEPTH = 64,
    parameter int CDT_W          = 7
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    nvdla_sdp_mcif_rd_responder_if.slave mcif,
    output logic                         mem_rd_en,
    output logic [WORD_ADDR_W-1:0]       mem_rd_addr,
    input  logic [RSP_DATA_W-1:0]        mem_rd_data,
    output logic                         cdt_err
);

    localparam logic [CDT_W-1:0] CDT_MAX = CDT_W'(LAT_FIFO_DEPTH);

    rd_state_e              state, state_nxt;
    logic [WORD_ADDR_W-1:0] word_addr, word_addr_nxt;
    logic [15:0]            beats_left, beats_left_nxt;
    logic [CDT_W-1:0]       credits, credits_nxt;
    logic                   cdt_err_q, cdt_err_nxt;
    logic                   inflight;
    logic                   issue;
    logic                   cdt_pop;
    logic                   rsp_take;
    logic [2:0]             occupancy;
    logic                   buf_valid;
    logic [1:0]             buf_count;
    rsp_pd_t                buf_din;
    logic [RSP_PD_W-1:0]    buf_dout;
    req_pd_t                req;
    logic                   unused_req_ofs;

    assign req            = req_pd_t'(mcif.sdp2mcif_rd_req_pd);
    assign unused_req_ofs = ^req.addr[BEAT_SHIFT-1:0];
    assign cdt_pop        = mcif.sdp2mcif_rd_cdt_lat_fifo_pop;
    assign rsp_take       = buf_valid && mcif.mcif2sdp_rd_rsp_ready;

    // A beat leaving the buffer this cycle frees its slot now; this keeps 1 beat/cycle with only 2 entries.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, rsp_take};

    always_comb begin
        state_nxt      = state;
        word_addr_nxt  = word_addr;
        beats_left_nxt = beats_left;
        issue          = 1'b0;
        case (state)
            IDLE: begin
                if (mcif.sdp2mcif_rd_req_valid) begin
                    word_addr_nxt  = word_addr_of(req.addr);
                    beats_left_nxt = {1'b0, req.size} + 16'd1;
                    state_nxt      = BURST;
                end
            end
            BURST: begin
                if ((beats_left != 16'd0) && (credits != '0) && (occupancy < 3'd2)) begin
                    issue          = 1'b1;
                    word_addr_nxt  = word_addr + WORD_ADDR_W'(1);
                    beats_left_nxt = beats_left - 16'd1;
                    if (beats_left == 16'd1) state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        credits_nxt = credits;
        cdt_err_nxt = cdt_err_q;
        if (issue && !cdt_pop) begin
            credits_nxt = credits - CDT_W'(1);
        end else if (cdt_pop && !issue) begin
            if (credits >= CDT_MAX) cdt_err_nxt = 1'b1;
            else                    credits_nxt = credits + CDT_W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state      <= IDLE;
            word_addr  <= '0;
            beats_left <= 16'd0;
            credits    <= CDT_MAX;
            cdt_err_q  <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_addr  <= word_addr_nxt;
            beats_left <= beats_left_nxt;
            credits    <= credits_nxt;
            cdt_err_q  <= cdt_err_nxt;
            inflight   <= issue;
        end
    end

    assign buf_din.mask = 1'b1;
    assign buf_din.data = mem_rd_data;

    nvdla_sdp_rsp_skid2 #(.W(RSP_PD_W)) u_rsp_buf (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .push     (inflight),
        .data_in  (buf_din),
        .pop      (rsp_take),
        .valid    (buf_valid),
        .data_out (buf_dout),
        .count    (buf_count)
    );

    // Outputs are forced quiet while reset is held, even before the first reset edge.
    assign mcif.sdp2mcif_rd_req_ready = (state == IDLE);
    assign mcif.mcif2sdp_rd_rsp_valid = buf_valid && !nvdla_core_rst;
    assign mcif.mcif2sdp_rd_rsp_pd    = nvdla_core_rst ? '0 : buf_dout;
    assign mem_rd_en                  = issue && !nvdla_core_rst;
    assign mem_rd_addr                = nvdla_core_rst ? '0 : word_addr;
    assign cdt_err                    = cdt_err_q && !nvdla_core_rst;

endmodule

// File: tb/tb_nvdla_sdp_mcif_rd_responder.sv
// Directed bench for the SDP MCIF read responder: burst table plus hand-written credit/reset sequences.
module tb_nvdla_sdp_mcif_rd_responder;
    import nvdla_sdp_mcif_rd_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b1;
    logic rst4 = 1'b1;

    nvdla_sdp_mcif_rd_responder_if ifa ();
    nvdla_sdp_mcif_rd_responder_if if4 ();

    logic        a_mem_en, b_mem_en, a_cdt_err, b_cdt_err;
    logic [28:0] a_mem_addr, b_mem_addr;
    logic [63:0] a_mem_data = '0;
    logic [63:0] b_mem_data = '0;

    nvdla_sdp_mcif_rd_responder dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .mcif           (ifa.slave),
        .mem_rd_en      (a_mem_en),
        .mem_rd_addr    (a_mem_addr),
        .mem_rd_data    (a_mem_data),
        .cdt_err        (a_cdt_err)
    );

    nvdla_sdp_mcif_rd_responder #(.LAT_FIFO_DEPTH(4), .CDT_W(3)) dut4 (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst4),
        .mcif           (if4.slave),
        .mem_rd_en      (b_mem_en),
        .mem_rd_addr    (b_mem_addr),
        .mem_rd_data    (b_mem_data),
        .cdt_err        (b_cdt_err)
    );

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {3'b101, a, 3'b010, ~a};
    endfunction

    // Backing memory: data for the strobed address is valid the following cycle.
    always @(posedge clk) if (a_mem_en) a_mem_data <= mem_word(a_mem_addr);
    always @(posedge clk) if (b_mem_en) b_mem_data <= mem_word(b_mem_addr);

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor for the default-depth instance. Something seen at negedge n is sampled by edge n+1.
    logic [28:0] a_iss[$];
    logic [64:0] a_rcv[$];
    int a_acc_e, a_first_en_e, a_last_en_e, a_first_rv_e, a_rdy_back_e, a_outst, a_rv_seen;
    bit a_busy, a_ovl, a_took;

    always @(negedge clk) begin
        bit take;
        a_took = 1'b0;
        if (!rst) begin
            take = ifa.mcif2sdp_rd_rsp_valid && ifa.mcif2sdp_rd_rsp_ready;
            if (ifa.sdp2mcif_rd_req_valid && ifa.sdp2mcif_rd_req_ready) begin
                a_acc_e = edge_n;
                a_busy  = 1'b1;
            end else if (a_busy && ifa.sdp2mcif_rd_req_ready) begin
                a_rdy_back_e = edge_n;
                a_busy       = 1'b0;
            end
            if (a_mem_en) begin
                if (a_iss.size() == 0) a_first_en_e = edge_n;
                a_last_en_e = edge_n;
                a_iss.push_back(a_mem_addr);
                if (a_outst - int'(take) >= 2) a_ovl = 1'b1;
                a_outst++;
            end
            if (ifa.mcif2sdp_rd_rsp_valid) begin
                if (a_first_rv_e < 0) a_first_rv_e = edge_n;
                a_rv_seen++;
            end
            if (take) begin
                a_rcv.push_back(ifa.mcif2sdp_rd_rsp_pd);
                a_outst--;
                a_took = 1'b1;
            end
        end
    end

    int b_iss, b_last_en_e, b_pop_e;
    bit b_pop_issue;

    always @(negedge clk) begin
        if (!rst4) begin
            if (b_mem_en) begin
                b_iss++;
                b_last_en_e = edge_n;
                if (if4.sdp2mcif_rd_cdt_lat_fifo_pop) b_pop_issue = 1'b1;
            end
            if (if4.sdp2mcif_rd_cdt_lat_fifo_pop) b_pop_e = edge_n;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_iss.delete();
        a_rcv.delete();
        a_acc_e = -1; a_first_en_e = -1; a_last_en_e = -1; a_first_rv_e = -1;
        a_rdy_back_e = -1; a_outst = 0; a_rv_seen = 0;
        a_busy = 1'b0; a_ovl = 1'b0;
    endtask

    task automatic reset_a();
        rst = 1'b1;
        ifa.sdp2mcif_rd_req_valid = 1'b0;
        ifa.mcif2sdp_rd_rsp_ready = 1'b0;
        ifa.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        tick();
        tick();
        clear_a();
        rst = 1'b0;
    endtask

    task automatic reset_4();
        rst4 = 1'b1;
        if4.sdp2mcif_rd_req_valid = 1'b0;
        if4.mcif2sdp_rd_rsp_ready = 1'b1;
        if4.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        tick();
        tick();
        b_iss = 0; b_last_en_e = -1; b_pop_e = -1; b_pop_issue = 1'b0;
        rst4 = 1'b0;
    endtask

    task automatic send_a(input logic [31:0] addr, input logic [14:0] size);
        int w = 0;
        ifa.sdp2mcif_rd_req_pd    = {size, addr};
        ifa.sdp2mcif_rd_req_valid = 1'b1;
        while (!ifa.sdp2mcif_rd_req_ready && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) chk("req_accept_timeout", 65'd0, 65'd1);
        tick();
        ifa.sdp2mcif_rd_req_valid = 1'b0;
    endtask

    task automatic send_4(input logic [31:0] addr, input logic [14:0] size);
        if4.sdp2mcif_rd_req_pd    = {size, addr};
        if4.sdp2mcif_rd_req_valid = 1'b1;
        tick();
        if4.sdp2mcif_rd_req_valid = 1'b0;
    endtask

    // Checks every issued address and returned beat against start+i; returns first bad index or -1.
    function automatic int order_err(input logic [28:0] first);
        logic [28:0] ea;
        for (int i = 0; i < a_rcv.size(); i++) begin
            ea = first + 29'(i);
            if (i >= a_iss.size() || a_iss[i] !== ea || a_rcv[i] !== {1'b1, mem_word(ea)}) return i;
        end
        return -1;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [14:0] size;
        logic [3:0]  rdy;        // rsp_ready per cycle, bit = cycle % 4
        logic [28:0] exp_first;
        logic [28:0] exp_last;
        int          exp_beats;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{32'h0000_1000, 15'd3,  4'b1111, 29'h0000200,  29'h0000203,  4};
        vt[1] = '{32'hFFFF_FFF8, 15'd1,  4'b1111, 29'h1FFFFFFF, 29'h0000000,  2};
        vt[2] = '{32'h0000_0107, 15'd9,  4'b1001, 29'h0000020,  29'h0000029,  10};
        vt[3] = '{32'h1234_5678, 15'd0,  4'b1111, 29'h2468ACF,  29'h2468ACF,  1};
        vt[4] = '{32'h0000_FFF8, 15'd31, 4'b0101, 29'h0001FFF,  29'h000201E,  32};

        ifa.sdp2mcif_rd_req_valid = 1'b0;
        ifa.sdp2mcif_rd_req_pd = '0;
        ifa.mcif2sdp_rd_rsp_ready = 1'b0;
        ifa.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        if4.sdp2mcif_rd_req_valid = 1'b0;
        if4.sdp2mcif_rd_req_pd = '0;
        if4.mcif2sdp_rd_rsp_ready = 1'b1;
        if4.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        clear_a();

        // Outputs quiet in reset, before and after the first edge.
        #1;
        chk("rst_pre_edge_outs", {a_mem_en, a_mem_addr, ifa.mcif2sdp_rd_rsp_valid, a_cdt_err}, 65'd0);
        chk("rst_pre_edge_pd", ifa.mcif2sdp_rd_rsp_pd, 65'd0);
        tick();
        chk("rst_outs", {a_mem_en, a_mem_addr, ifa.mcif2sdp_rd_rsp_valid, a_cdt_err}, 65'd0);
        reset_a();
        chk("req_ready_after_rst", ifa.sdp2mcif_rd_req_ready, 65'd1);

        for (int v = 0; v < 5; v++) begin
            reset_a();
            ifa.mcif2sdp_rd_rsp_ready = vt[v].rdy[0];
            send_a(vt[v].addr, vt[v].size);
            for (int k = 1; k < 300 && a_rcv.size() < vt[v].exp_beats; k++) begin
                ifa.mcif2sdp_rd_rsp_ready = vt[v].rdy[k % 4];
                tick();
            end
            ifa.mcif2sdp_rd_rsp_ready = 1'b1;
            repeat (6) tick();
            chk($sformatf("v%0d_issued", v),   a_iss.size(), vt[v].exp_beats);
            chk($sformatf("v%0d_returned", v), a_rcv.size(), vt[v].exp_beats);
            chk($sformatf("v%0d_order_err_idx", v), order_err(vt[v].exp_first), -1);
            chk($sformatf("v%0d_last_addr", v), (a_iss.size() > 0) ? a_iss[a_iss.size()-1] : 29'h0, vt[v].exp_last);
            chk($sformatf("v%0d_buf_overfill", v), a_ovl, 65'd0);
            chk($sformatf("v%0d_first_en_edge", v), a_first_en_e, a_acc_e + 1);
            // Accepted by edge T=acc_e+1; rsp_valid rising at edge T+2 is first seen at negedge acc_e+3.
            chk($sformatf("v%0d_first_rsp_edge", v), a_first_rv_e, a_acc_e + 3);
            chk($sformatf("v%0d_ready_back_edge", v), a_rdy_back_e, a_last_en_e + 1);
            if (vt[v].rdy == 4'b1111)
                chk($sformatf("v%0d_issue_span", v), a_last_en_e - a_first_en_e, vt[v].exp_beats - 1);
        end

        // Depth-4 instance: credits run out after 4 beats; one pop releases the 5th the next cycle.
        reset_4();
        send_4(32'h0, 15'd7);
        repeat (12) tick();
        chk("d4_stall_issued", b_iss, 4);
        if4.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
        tick();
        if4.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        repeat (6) tick();
        chk("d4_after_pop_issued", b_iss, 5);
        chk("d4_pop_to_issue_edge", b_last_en_e, b_pop_e + 1);

        // Pop in the same cycle as the 3rd issue (credits 2): credits hold, so 5 beats total.
        reset_4();
        send_4(32'h0, 15'd7);
        tick();
        tick();
        if4.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
        tick();
        if4.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        repeat (10) tick();
        chk("d4_pop_with_issue", b_pop_issue, 65'd1);
        chk("d4_same_cycle_issued", b_iss, 5);

        // Pop at full credits: error sticks, credits saturate at 64.
        reset_a();
        chk("cdt_err_after_rst", a_cdt_err, 65'd0);
        ifa.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
        tick();
        ifa.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        chk("cdt_err_set", a_cdt_err, 65'd1);
        ifa.mcif2sdp_rd_rsp_ready = 1'b1;
        send_a(32'h0, 15'd64);
        repeat (90) tick();
        chk("sat_credit_issued", a_iss.size(), 64);
        chk("cdt_err_sticky", a_cdt_err, 65'd1);
        reset_a();
        chk("cdt_err_cleared", a_cdt_err, 65'd0);

        // Reset during beat 3 of a 16-beat burst.
        ifa.mcif2sdp_rd_rsp_ready = 1'b1;
        send_a(32'h0000_4000, 15'd15);
        for (int i = 0; i < 20 && a_iss.size() < 3; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_outs_now", {a_mem_en, a_mem_addr, ifa.mcif2sdp_rd_rsp_valid, a_cdt_err}, 65'd0);
        chk("midrst_pd_now", ifa.mcif2sdp_rd_rsp_pd, 65'd0);
        tick();
        chk("midrst_outs_held", {a_mem_en, a_mem_addr, ifa.mcif2sdp_rd_rsp_valid, a_cdt_err}, 65'd0);
        tick();
        clear_a();
        rst = 1'b0;
        chk("midrst_req_ready", ifa.sdp2mcif_rd_req_ready, 65'd1);
        repeat (8) tick();
        chk("midrst_no_stale_beat", a_rv_seen, 0);
        send_a(32'h0, 15'd64);
        repeat (90) tick();
        chk("midrst_credits_restored", a_iss.size(), 64);

        // Maximum size with credits returned as beats are consumed.
        reset_a();
        ifa.mcif2sdp_rd_rsp_ready = 1'b1;
        send_a(32'h0, 15'h7FFF);
        for (int i = 0; i < 34000 && a_rcv.size() < 32768; i++) begin
            ifa.sdp2mcif_rd_cdt_lat_fifo_pop = a_took;
            tick();
        end
        ifa.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
        repeat (6) tick();
        chk("max_issued", a_iss.size(), 32768);
        chk("max_returned", a_rcv.size(), 32768);
        chk("max_order_err_idx", order_err(29'h0), -1);
        chk("max_issue_span", a_last_en_e - a_first_en_e, 32767);
        chk("max_req_ready", ifa.sdp2mcif_rd_req_ready, 65'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nvdla_sdp_mcif_rd_responder.md
NVDLA_SDP_MCIF_RD_RESPONDER -- requirements
Module: nvdla_sdp_mcif_rd_responder

Interface
REQ-001 Parameter LAT_FIFO_DEPTH, default 64: the number of response beats the SDP read client can absorb, i.e. the initial credit count.
REQ-002 Parameter CDT_W, default 7: credit counter width; CDT_W SHALL satisfy 2^CDT_W > LAT_FIFO_DEPTH.
REQ-003 nvdla_core_clk  in  1  the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 nvdla_core_rst  in  1  reset; it SHALL be synchronous and active-high.
REQ-005 sdp2mcif_rd_req_valid  in  1  read request valid.
REQ-006 sdp2mcif_rd_req_ready  out  1  read request accepted.
REQ-007 sdp2mcif_rd_req_pd  in  47  request payload: [31:0] byte address, [46:32] size, where size = beats-1 and one beat = 8 bytes.
REQ-008 mcif2sdp_rd_rsp_valid  out  1  response beat valid.
REQ-009 mcif2sdp_rd_rsp_ready  in  1  response beat accepted.
REQ-010 mcif2sdp_rd_rsp_pd  out  65  response payload: [63:0] data, [64] mask (constant 1).
REQ-011 sdp2mcif_rd_cdt_lat_fifo_pop  in  1  client freed one latency-FIFO entry; each pulse returns one credit.
REQ-012 mem_rd_en  out  1  backing-memory read strobe.
REQ-013 mem_rd_addr  out  29  backing-memory 8-byte word address.
REQ-014 mem_rd_data  in  64  backing-memory read data, valid exactly 1 cycle after mem_rd_en.
REQ-015 cdt_err  out  1  sticky flag: credit overflow occurred.

Function
REQ-016 FSM states SHALL be IDLE and BURST; req_ready SHALL equal (state==IDLE).
REQ-017 IDLE->BURST on req_valid&&req_ready: latch word address = pd[31:3] (pd[2:0] ignored) and beats_left = pd[46:32]+1 (16-bit).
REQ-018 In BURST, mem_rd_en SHALL assert when beats_left!=0 && credits!=0 && (buf_count + inflight) < 2.
REQ-019 Each mem_rd_en SHALL: drive the current word address, then increment it modulo 2^29 (wrap 0x1FFFFFFF->0); decrement beats_left; decrement credits.
REQ-020 BURST->IDLE in the same cycle as the mem_rd_en that issues the last beat; the next request SHALL be acceptable the following cycle.
REQ-021 Data returned 1 cycle after mem_rd_en SHALL be written into a 2-entry FIFO (output buffer); mcif2sdp_rd_rsp_valid = buffer non-empty, pd = head entry {1'b1, data}.
REQ-022 Beats SHALL be returned in issue order, with no loss or duplication under any rsp_ready pattern.
REQ-023 Latency: request accepted at cycle T -> mem_rd_en at T+1 -> rsp_valid at T+2 when credits are available and rsp_ready=1.
REQ-024 Sustained throughput SHALL be 1 beat/cycle when rsp_ready=1 and credits>0.
REQ-025 Credits: decrement per mem_rd_en, increment per cdt_lat_fifo_pop; when both occur in the same cycle, credits SHALL be unchanged.
REQ-026 credits==0 SHALL stall issue; the pending beat SHALL issue in the cycle after a pop arrives.
REQ-027 A pop with credits==LAT_FIFO_DEPTH and no same-cycle issue SHALL saturate credits and set cdt_err until reset.
REQ-028 A size of 0x7FFF SHALL produce exactly 32768 beats.

Reset
REQ-029 On nvdla_core_rst=1 at a clock edge: state=IDLE, beats_left=0, credits=LAT_FIFO_DEPTH, buffer empty, inflight=0, cdt_err=0.
REQ-030 While in reset, every output except sdp2mcif_rd_req_ready SHALL be 0; req_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-031 Reset asserted mid-burst SHALL abandon the burst: buffered and in-flight data discarded, credits restored to LAT_FIFO_DEPTH.

Structure
REQ-032 A shared package SHALL hold the request/response pd field offsets, the 8-byte beat size constant, and the FSM state enum.
REQ-033 The 2-entry output buffer SHALL be a sub-module, nvdla_sdp_rsp_skid2, with push/data_in/pop/valid/data_out/count ports.

Verification
REQ-034 Request addr=0x00001000, size=3, rsp_ready=1 -> mem_rd_addr 0x200,0x201,0x202,0x203 on consecutive cycles; 4 beats returned; first rsp_valid at T+2.
REQ-035 LAT_FIFO_DEPTH=4, no pops, request size=7 -> exactly 4 beats issued then stall; one pop -> fifth beat issued the next cycle.
REQ-036 Request addr=0xFFFFFFF8, size=1 -> mem_rd_addr 0x1FFFFFFF then 0x00000000.
REQ-037 rsp_ready toggling 1,0,0,1 during a size=9 burst -> 10 beats delivered in order; mem_rd_en never issues with buf_count+inflight>=2.
REQ-038 Pop and mem_rd_en in the same cycle with credits=2 -> credits remain 2; a pop at credits=64 with no issue -> cdt_err=1 and credits stay 64.
REQ-039 Reset asserted at beat 3 of a size=15 burst -> outputs 0 during reset; req_ready=1 and credits=64 afterwards; no stale beat appears on the response port.
